// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and
// the width helper used to size the sequencing counter.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLLRST = 2'd0,
        WAIT   = 2'd1,
        FILTER = 2'd2,
        RUN    = 2'd3
    } state_t;

    // Bits needed to hold values 0 .. value-1 (returns 0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset to 0.
// Reused wherever a slow status bit crosses into a new clock domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, filters the lock flag and releases the system reset
// only after a sustained lock; retries stalled PLLs and counts lock losses.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int LOCK_FILTER = 16384,
    parameter int TIMEOUT     = 262144,
    parameter int PLLRST_LEN  = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             sw_reset,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [CNT_W-1:0] loss_cnt,
    output logic [CNT_W-1:0] retry_cnt
);

    localparam int CW = clog2(max3(LOCK_FILTER, TIMEOUT, PLLRST_LEN)) + 1;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          locked_s;
    logic          loss_inc, retry_inc;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PLLRST;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        loss_inc   = 1'b0;
        retry_inc  = 1'b0;

        // sw_reset overrides every transition and suppresses event counting.
        if (sw_reset) begin
            state_next = PLLRST;
            cnt_next   = '0;
        end else begin
            case (state)
                PLLRST: begin
                    if (cnt == CW'(PLLRST_LEN - 1)) begin
                        state_next = WAIT;
                        cnt_next   = '0;
                    end
                end
                WAIT: begin
                    if (locked_s) begin
                        state_next = FILTER;
                        cnt_next   = '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state_next = PLLRST;
                        cnt_next   = '0;
                        retry_inc  = 1'b1;
                    end
                end
                FILTER: begin
                    if (!locked_s) begin
                        state_next = WAIT;
                        cnt_next   = '0;
                    end else if (cnt == CW'(LOCK_FILTER - 1)) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end
                end
                RUN: begin
                    cnt_next = '0;
                    if (!locked_s) begin
                        state_next = WAIT;
                        loss_inc   = 1'b1;
                    end
                end
                default: begin
                    state_next = PLLRST;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Event counters saturate and survive sw_reset; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            if (loss_inc && (loss_cnt != '1)) begin
                loss_cnt <= loss_cnt + CNT_W'(1);
            end
            if (retry_inc && (retry_cnt != '1)) begin
                retry_cnt <= retry_cnt + CNT_W'(1);
            end
        end
    end

    assign pll_rst   = (state == PLLRST);
    assign sys_rst_n = (state == RUN);
    assign ready     = (state == RUN);

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with short timing parameters;
// stimulus segments feed a scoreboard that is compared every cycle.
module tb_pll_reset_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          locked;
    logic          sw_reset;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          ready;
    logic [CW-1:0] loss_cnt;
    logic [CW-1:0] retry_cnt;

    typedef struct {
        int           len;
        logic         locked;
        logic         sw_reset;
        logic         pll_rst;
        logic         sys_rst_n;
        logic [CW-1:0] loss;
        logic [CW-1:0] retry;
    } seg_t;

    typedef struct {
        int            edge_no;
        logic          pll_rst;
        logic          sys_rst_n;
        logic [CW-1:0] loss;
        logic [CW-1:0] retry;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_no  = 0;

    pll_reset_sequencer #(
        .LOCK_FILTER (16),
        .TIMEOUT     (64),
        .PLLRST_LEN  (4),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked    (locked),
        .sw_reset  (sw_reset),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .loss_cnt  (loss_cnt),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    function automatic seg_t mk(input int len, input logic lk, input logic sw, input logic pll,
                                input logic sys, input int loss, input int retry);
        seg_t s;
        s.len       = len;
        s.locked    = lk;
        s.sw_reset  = sw;
        s.pll_rst   = pll;
        s.sys_rst_n = sys;
        s.loss      = CW'(loss);
        s.retry     = CW'(retry);
        return s;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard empty", 8'd1, 8'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("edge %0d pll_rst", e.edge_no), 8'(pll_rst), 8'(e.pll_rst));
            check($sformatf("edge %0d sys_rst_n", e.edge_no), 8'(sys_rst_n), 8'(e.sys_rst_n));
            check($sformatf("edge %0d ready", e.edge_no), 8'(ready), 8'(e.sys_rst_n));
            check($sformatf("edge %0d loss_cnt", e.edge_no), 8'(loss_cnt), 8'(e.loss));
            check($sformatf("edge %0d retry_cnt", e.edge_no), 8'(retry_cnt), 8'(e.retry));
        end
    endtask

    // Drive each segment's inputs at the falling edge, push what the next
    // rising edge must produce, then compare at the following falling edge.
    task automatic run_segments();
        seg_t s;
        exp_t e;
        while (segs.size() > 0) begin
            s = segs.pop_front();
            for (int i = 0; i < s.len; i++) begin
                locked   = s.locked;
                sw_reset = s.sw_reset;
                edge_no++;
                e.edge_no   = edge_no;
                e.pll_rst   = s.pll_rst;
                e.sys_rst_n = s.sys_rst_n;
                e.loss      = s.loss;
                e.retry     = s.retry;
                sb.push_back(e);
                @(posedge clk);
                @(negedge clk);
                compare_head();
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " pll_rst"}, 8'(pll_rst), 8'd1);
        check({tag, " sys_rst_n"}, 8'(sys_rst_n), 8'd0);
        check({tag, " ready"}, 8'(ready), 8'd0);
        check({tag, " loss_cnt"}, 8'(loss_cnt), 8'd0);
        check({tag, " retry_cnt"}, 8'(retry_cnt), 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        locked   = 1'b0;
        sw_reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Locked from edge 10: release at 10 + 18 = 28.
        segs.push_back(mk(3,  0, 0, 1, 0, 0, 0));
        segs.push_back(mk(6,  0, 0, 0, 0, 0, 0));
        segs.push_back(mk(18, 1, 0, 0, 0, 0, 0));
        segs.push_back(mk(13, 1, 0, 0, 1, 0, 0));
        // Three-cycle lock drop in RUN (edges 41-43): falls at 43, back at 44 + 18.
        segs.push_back(mk(2,  0, 0, 0, 1, 0, 0));
        segs.push_back(mk(1,  0, 0, 0, 0, 1, 0));
        segs.push_back(mk(18, 1, 0, 0, 0, 1, 0));
        segs.push_back(mk(9,  1, 0, 0, 1, 1, 0));
        // One-cycle sw_reset in RUN at edge 71.
        segs.push_back(mk(1,  1, 1, 1, 0, 1, 0));
        segs.push_back(mk(3,  1, 0, 1, 0, 1, 0));
        segs.push_back(mk(17, 1, 0, 0, 0, 1, 0));
        segs.push_back(mk(4,  1, 0, 0, 1, 1, 0));
        // FILTER entered at 101; one-cycle drop at cnt=10 (edge 112) restarts it.
        segs.push_back(mk(1,  1, 1, 1, 0, 1, 0));
        segs.push_back(mk(3,  1, 0, 1, 0, 1, 0));
        segs.push_back(mk(12, 1, 0, 0, 0, 1, 0));
        segs.push_back(mk(1,  0, 0, 0, 0, 1, 0));
        segs.push_back(mk(18, 1, 0, 0, 0, 1, 0));
        segs.push_back(mk(5,  1, 0, 0, 1, 1, 0));
        // Park mid-FILTER for the asynchronous reset.
        segs.push_back(mk(1,  1, 1, 1, 0, 1, 0));
        segs.push_back(mk(3,  1, 0, 1, 0, 1, 0));
        segs.push_back(mk(6,  1, 0, 0, 0, 1, 0));
        run_segments();

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        edge_no = 0;

        // Lock never arrives: 4-cycle pll_rst pulse every 68, retry saturates at 15.
        segs.push_back(mk(3, 0, 0, 1, 0, 0, 0));
        for (int r = 1; r <= 16; r++) begin
            segs.push_back(mk(64, 0, 0, 0, 0, 0, (r - 1 > 15) ? 15 : r - 1));
            segs.push_back(mk(4,  0, 0, 1, 0, 0, (r > 15) ? 15 : r));
        end
        // sw_reset held keeps pll_rst high; pulse length restarts after release.
        segs.push_back(mk(10, 0, 1, 1, 0, 0, 15));
        segs.push_back(mk(3,  0, 0, 1, 0, 0, 15));
        segs.push_back(mk(5,  0, 0, 0, 0, 0, 15));
        run_segments();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the ULX3S clock PLL wrapper (375/75/25 MHz).
- Consumes the PLL `locked` flag and drives the PLL reset input.
- Produces a clean, filtered system reset and ready indication for the rest of the SoC.
- Runs on the free-running 25 MHz board oscillator. It retries the PLL if lock never arrives and counts lock-loss events.

Parameters:
- LOCK_FILTER, 16384: consecutive synchronized-locked cycles required before reset release.
- TIMEOUT, 262144: cycles allowed in WAIT without lock before the PLL is re-reset.
- PLLRST_LEN, 16: cycles pll_rst is held high per PLL reset pulse.
- CNT_W, 8: width of the lock-loss and retry event counters.

Ports:
- clk  in  1  free-running 25 MHz oscillator clock.
- rst_n  in  1  asynchronous active-low reset. Only clk and rst_n are fixed; all else is synchronous to clk.
- locked  in  1  PLL lock flag, asynchronous to clk.
- sw_reset  in  1  synchronous request to restart the whole sequence. Level or pulse; sampled each cycle.
- pll_rst  out  1  active-high reset to the PLL RST pin.
- sys_rst_n  out  1  active-low system reset to downstream logic.
- ready  out  1  high while in RUN.
- loss_cnt  out  CNT_W  saturating count of lock losses while in RUN.
- retry_cnt  out  CNT_W  saturating count of WAIT timeouts.

Behaviour:
- Reset values while rst_n low, applied asynchronously:
  - state = PLLRST, cnt = 0
  - pll_rst = 1, sys_rst_n = 0, ready = 0
  - loss_cnt = 0, retry_cnt = 0
  - both synchronizer flops = 0
- locked passes through a 2-flop synchronizer; locked_s lags locked by 2 edges.
- Outputs are Moore decodes of the registered state:
  - pll_rst = (state == PLLRST)
  - sys_rst_n = ready = (state == RUN)
  - Both are driven from flops, with no combinational path from the inputs.
- Single down-counter-free up-counter `cnt`. Width = clog2(max(LOCK_FILTER, TIMEOUT, PLLRST_LEN)) + 1. cnt is cleared on every state change.
- States and transitions:
  - PLLRST: cnt increments each cycle. When cnt == PLLRST_LEN-1, go to WAIT.
  - WAIT: cnt increments each cycle.
    - locked_s = 1: go to FILTER.
    - Else, when cnt == TIMEOUT-1: go to PLLRST and increment retry_cnt.
  - FILTER: while locked_s = 1, cnt increments.
    - locked_s = 0: go to WAIT (timeout restarts from 0).
    - When locked_s = 1 and cnt == LOCK_FILTER-1: go to RUN.
  - RUN: when locked_s = 0, go to WAIT and increment loss_cnt. sys_rst_n drops on that same edge.
- sw_reset = 1 in any state forces state = PLLRST and cnt = 0 on the next edge.
  - sw_reset has priority over every other transition.
  - Counters do not increment on that edge.
  - sw_reset held high keeps pll_rst high.
- Event counters saturate at 2^CNT_W-1 and never wrap. They are cleared only by rst_n, not by sw_reset.
- Release latency from the first edge E0 at which locked is sampled high:
  - locked_s goes high at E1.
  - FILTER is entered at E2.
  - RUN, sys_rst_n and ready go high at edge E0 + LOCK_FILTER + 2, provided locked stays high.
- A locked glitch shorter than one clk period may be missed; this is acceptable.
- A single-cycle locked_s drop during FILTER restarts filtering.
- rst_n asserted mid-operation returns everything to reset values immediately. Release of rst_n needs no internal synchronizer: the board reset is already synchronized upstream.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state encoding (PLLRST=0, WAIT=1, FILTER=2, RUN=3, 2 bits);
  - a clog2 width function used for CNT sizing.
- One natural sub-module: sync_2ff, a generic 1-bit 2-flop synchronizer with async active-low reset to 0. It is reused elsewhere for CDC of status bits.

Test Plan:
All scenarios use LOCK_FILTER=16, TIMEOUT=64, PLLRST_LEN=4, CNT_W=4.
- Reset release, locked high from cycle 10 onward:
  - pll_rst high for exactly edges 1-4 after reset release;
  - sys_rst_n and ready rise at edge 10+18 = 28 and stay high;
  - loss_cnt = 0.
- locked held low:
  - pll_rst re-pulses for 4 cycles every 68 cycles;
  - retry_cnt counts 1, 2, 3 and saturates at 15 after 15 timeouts;
  - sys_rst_n stays 0.
- In FILTER, locked drops for 1 cycle at cnt=10 then returns:
  - state goes back to WAIT;
  - sys_rst_n rises 18 edges after the second rise;
  - retry_cnt unchanged.
- In RUN, locked drops for 3 cycles:
  - sys_rst_n and ready fall 3 edges after the locked fall (2 sync + 1);
  - loss_cnt = 1;
  - re-release 18 edges after locked returns.
- sw_reset pulsed for 1 cycle in RUN:
  - pll_rst high for 4 cycles starting on the next edge;
  - sys_rst_n low on that edge;
  - loss_cnt and retry_cnt unchanged.
- rst_n asserted asynchronously mid-FILTER:
  - all outputs return to reset values without waiting for a clk edge;
  - counters read 0.
